adc_seq_averager: RTL and testbench
===================================

Name: adc_seq_averager

Overview:
- Parametrised successor to the modular ADC black-box wrapper. Drives the ADC command stream (Avalon-ST) and consumes its response stream.
- Sweeps a configurable list of NUM_CH channels and averages 2^AVG_LOG2 samples per channel.
- Emits one averaged result per channel, in single-shot or continuous mode.
- Sits between the ADC IP and the register/readout logic.

Parameters:
NUM_CH, 4, channels per sweep (1..16)
CH_W, 5, ADC channel field width
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of samples averaged per channel (0..6)
CH_MAP, {5'd4,5'd3,5'd2,5'd1}, packed NUM_CH*CH_W list; entry 0 in LSBs = first channel swept
TIMEOUT_CYC, 1023, max cycles waiting for a response before retry

Ports:
clock_clk  in  1  single clock
reset_sink_reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a sweep when idle
continuous  in  1  1 = restart sweep after completion
command_valid  out  1  ADC command valid
command_channel  out  CH_W  ADC channel to convert
command_startofpacket  out  1  first command of sweep
command_endofpacket  out  1  last command of sweep
command_ready  in  1  ADC accepts command
response_valid  in  1  ADC sample valid (no backpressure)
response_channel  in  CH_W  channel of sample
response_data  in  DATA_W  sample
result_valid  out  1  one-cycle pulse, averaged result ready
result_index  out  $clog2(NUM_CH) (min 1)  position in CH_MAP
result_data  out  DATA_W  averaged sample
sweep_done  out  1  one-cycle pulse with last result of sweep
busy  out  1  high outside IDLE
err_mismatch  out  1  sticky: response channel differed from expected
err_timeout  out  1  sticky: response timeout occurred
err_clear  in  1  clears both sticky errors

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0. Accumulator, channel index and sample counters 0. Sticky errors cleared.
- States:
  - IDLE: start=1 -> ISSUE with idx=0, smp=0.
  - ISSUE: command_valid=1 with command_channel=CH_MAP[idx]. Hold valid and channel stable until command_ready=1. On the handshake cycle -> WAIT and clear the timeout counter.
  - WAIT: count cycles. On response_valid with response_channel==CH_MAP[idx]: acc += response_data (zero-extended to DATA_W+AVG_LOG2 bits), then -> ACC.
  - WAIT, mismatched response_valid: sample discarded, err_mismatch set, -> ISSUE with the same idx/smp (retry).
  - WAIT, counter reaches TIMEOUT_CYC with no response: err_timeout set, -> ISSUE (retry).
  - ACC, smp < 2^AVG_LOG2-1: smp++, -> ISSUE.
  - ACC, otherwise, next cycle: result_valid=1, result_index=idx, result_data=acc>>AVG_LOG2 (truncating). Acc and smp cleared.
  - ACC, last idx: sweep_done=1 on the same cycle as result_valid. Then continuous=1 -> ISSUE with idx=0; continuous=0 -> IDLE.
  - ACC, not last idx: idx++, -> ISSUE.
- Packet markers (on the command only, qualified by command_valid):
  - command_startofpacket=1 when idx=0 and smp=0.
  - command_endofpacket=1 when idx=NUM_CH-1 and smp=2^AVG_LOG2-1.
- start while busy is ignored.
- Deasserting continuous mid-sweep completes the current sweep, then -> IDLE.
- Retries do not change acc, smp or idx.
- response_valid outside WAIT is ignored and sets no error.
- Accumulator cannot overflow (width DATA_W+AVG_LOG2).
- err_clear has priority over a same-cycle error set.
- Reset mid-operation takes effect at the next edge: command_valid drops and no result is emitted.
- Latency, AVG_LOG2=0, ready and response immediate: response cycle -> result_valid 2 cycles later.

Optional Feature:
Macro ADC_SEQ_THRESH_EN.
- Defined:
  - Adds input thresh_hi [DATA_W] and output thresh_alarm [NUM_CH], registered.
  - On each result_valid, thresh_alarm[result_index] <= (result_data > thresh_hi). The bit stays at that value until that channel's next result, or reset.
- Undefined:
  - Ports absent, no extra logic.

Test Plan:
- NUM_CH=3, AVG_LOG2=2, CH_MAP={8,3,1}; ADC model ready=1, response 3 cycles after command, data = channel*100 + sample#(0..3); pulse start -> results idx0=101, idx1=301, idx2=801, in order. sweep_done with idx2. SOP only on the first command, EOP only on the 12th. Then IDLE, busy=0.
- Hold command_ready=0 for 10 cycles during ISSUE -> command_valid and command_channel stable throughout; exactly one command accepted.
- Inject response_channel=7 while expecting 3 -> err_mismatch=1, command reissued for channel 3, final average unchanged. err_clear -> err_mismatch=0.
- Suppress one response; TIMEOUT_CYC=20 -> err_timeout=1 at cycle 20 of WAIT, retry, correct result. Pulse start while busy -> no effect.
- continuous=1 -> back-to-back sweeps with no idle cycle between. Drop continuous during sweep 2 -> sweep 2 completes, then IDLE. Assert reset mid-WAIT -> next cycle all outputs 0, no result_valid.
- With ADC_SEQ_THRESH_EN, thresh_hi=500 -> thresh_alarm=3'b100 after the first sweep.

Source files
------------

// File: rtl/adc_seq_averager.sv
// Sequences ADC commands over CH_MAP and emits one result per channel. Each result is the average of 2^AVG_LOG2 samples, truncated.
// Latency: the last sample's response cycle -> result_valid two cycles later. Optional threshold alarms are enabled with ADC_SEQ_THRESH_EN.
// Backpressure: command is held until command_ready. Responses cannot be stalled; an unexpected or missing response triggers a retry.
module adc_seq_averager #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 5,
  parameter int DATA_W = 12,
  parameter int AVG_LOG2 = 2,
  parameter logic [NUM_CH*CH_W-1:0] CH_MAP = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int TIMEOUT_CYC = 1023,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset,
  input  logic              start,
  input  logic              continuous,
  output logic              command_valid,
  output logic [CH_W-1:0]   command_channel,
  output logic              command_startofpacket,
  output logic              command_endofpacket,
  input  logic              command_ready,
  input  logic              response_valid,
  input  logic [CH_W-1:0]   response_channel,
  input  logic [DATA_W-1:0] response_data,
  output logic              result_valid,
  output logic [IDX_W-1:0]  result_index,
  output logic [DATA_W-1:0] result_data,
  output logic              sweep_done,
  output logic              busy,
  output logic              err_mismatch,
  output logic              err_timeout,
  input  logic              err_clear
`ifdef ADC_SEQ_THRESH_EN
  ,
  input  logic [DATA_W-1:0] thresh_hi,
  output logic [NUM_CH-1:0] thresh_alarm
`endif
);

  localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACC   = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [SMP_W-1:0] smp;
  logic [ACC_W-1:0] acc;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CH_W-1:0]  exp_ch;
  logic             rsp_match;
  logic             mismatch_evt;
  logic             timeout_evt;

  // Channel currently being converted, looked up from the sweep list
  always_comb begin
    exp_ch = CH_MAP[int'(idx)*CH_W +: CH_W];
  end

  assign rsp_match     = (response_channel == exp_ch);
  assign mismatch_evt  = (state == S_WAIT) && response_valid && !rsp_match;
  assign timeout_evt   = (state == S_WAIT) && !response_valid && (tmo_cnt == TMO_LAST);

  assign command_valid         = (state == S_ISSUE);
  assign command_channel       = command_valid ? exp_ch : '0;
  assign command_startofpacket = command_valid && (idx == '0) && (smp == '0);
  assign command_endofpacket   = command_valid && (idx == LAST_IDX) && (smp == LAST_SMP);
  assign busy                  = (state != S_IDLE);

  // Sweep sequencer: issue, wait for the matching sample, accumulate, emit averages
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      smp          <= '0;
      acc          <= '0;
      tmo_cnt      <= '0;
      result_valid <= 1'b0;
      result_index <= '0;
      result_data  <= '0;
      sweep_done   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      sweep_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            idx   <= '0;
            smp   <= '0;
          end
        end
        S_ISSUE: begin
          if (command_ready) begin
            state   <= S_WAIT;
            tmo_cnt <= '0;
          end
        end
        S_WAIT: begin
          // A wrong channel or a silent ADC both retry the same command;
          // idx, smp and acc are left untouched so the average is unaffected.
          if (response_valid) begin
            if (rsp_match) begin
              acc   <= acc + ACC_W'(response_data);
              state <= S_ACC;
            end else begin
              state <= S_ISSUE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_ISSUE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_ACC: begin
          if (smp != LAST_SMP) begin
            smp   <= smp + 1'b1;
            state <= S_ISSUE;
          end else begin
            result_valid <= 1'b1;
            result_index <= idx;
            result_data  <= DATA_W'(acc >> AVG_LOG2);
            acc          <= '0;
            smp          <= '0;
            if (idx == LAST_IDX) begin
              // Restart goes straight to ISSUE so continuous sweeps have no gap
              sweep_done <= 1'b1;
              idx        <= '0;
              state      <= continuous ? S_ISSUE : S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a clear wins over a same-cycle error
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else if (err_clear) begin
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (mismatch_evt) err_mismatch <= 1'b1;
      if (timeout_evt)  err_timeout  <= 1'b1;
    end
  end

`ifdef ADC_SEQ_THRESH_EN
  // Per-channel alarm refreshed whenever that channel's average is published
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      thresh_alarm <= '0;
    end else if (result_valid) begin
      thresh_alarm[result_index] <= (result_data > thresh_hi);
    end
  end
`endif

endmodule

// File: tb/tb_adc_seq_averager.sv
// Bench for adc_seq_averager: ADC responder model plus per-channel averaging reference.
// Results are scored on index, data, sweep_done and arrival cycle.
// The responder can stall ready, corrupt the channel or drop a response.
module tb_adc_seq_averager;
  localparam int NUM_CH = 3;
  localparam int CH_W = 5;
  localparam int DATA_W = 12;
  localparam int AVG_LOG2 = 2;
  localparam int NSMP = 4;
  localparam int TIMEOUT_CYC = 20;
  localparam logic [NUM_CH*CH_W-1:0] MAP = {5'd8, 5'd3, 5'd1};

  typedef struct { int idx; int data; bit done; int cyc; } res_t;
  typedef struct { int ch; bit sop; bit eop; } cmd_t;

  logic clk = 1'b0;
  logic rst, start, continuous, err_clear;
  logic command_valid, command_startofpacket, command_endofpacket, command_ready;
  logic [CH_W-1:0] command_channel, response_channel;
  logic response_valid;
  logic [DATA_W-1:0] response_data, result_data;
  logic result_valid, sweep_done, busy, err_mismatch, err_timeout;
  logic [1:0] result_index;
`ifdef ADC_SEQ_THRESH_EN
  logic [DATA_W-1:0] thresh_hi;
  logic [NUM_CH-1:0] thresh_alarm;
`endif

  adc_seq_averager #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2),
    .CH_MAP(MAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock_clk(clk), .reset_sink_reset(rst), .start(start), .continuous(continuous),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .result_valid(result_valid), .result_index(result_index), .result_data(result_data),
    .sweep_done(sweep_done), .busy(busy), .err_mismatch(err_mismatch),
    .err_timeout(err_timeout), .err_clear(err_clear)
`ifdef ADC_SEQ_THRESH_EN
    , .thresh_hi(thresh_hi), .thresh_alarm(thresh_alarm)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // responder / reference model state
  int   cyc = 0;
  bit   pend = 0;
  int   pend_dly, pend_ch, pend_hs_cyc;
  bit   ready_hold = 0, inj_arm = 0, sup_arm = 0, seq_data = 0;
  int   inj_at = -1, sup_cyc = -1, tmo_cyc = -1;
  int   sums[NUM_CH];
  int   cnts[NUM_CH];
  int   map_ch[NUM_CH] = '{1, 3, 8};
  res_t exp_q[$];
  res_t got_q[$];
  cmd_t cmd_log[$];

  // ADC model and result monitor, all on the falling edge
  initial begin
    command_ready = 1'b0; response_valid = 1'b0;
    response_channel = '0; response_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin sums[i] = 0; cnts[i] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      if (result_valid) begin
        res_t r;
        r.idx = int'(result_index); r.data = int'(result_data); r.done = sweep_done; r.cyc = cyc;
        got_q.push_back(r);
      end
      if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
      response_valid = 1'b0;
      if (pend) begin
        pend_dly--;
        if (pend_dly == 0) begin
          pend = 0;
          if (sup_arm) begin
            sup_arm = 0;
            sup_cyc = pend_hs_cyc;
          end else if (inj_arm && pend_ch == 3) begin
            inj_arm = 0;
            inj_at = cmd_log.size();
            response_valid = 1'b1;
            response_channel = CH_W'(7);
            response_data = DATA_W'($urandom_range(0, 4095));
          end else begin
            int pos, d;
            pos = 0;
            for (int i = 0; i < NUM_CH; i++) if (map_ch[i] == pend_ch) pos = i;
            d = seq_data ? pend_ch * 100 + cnts[pos] : int'($urandom_range(0, 4095));
            response_valid = 1'b1;
            response_channel = CH_W'(pend_ch);
            response_data = DATA_W'(d);
            sums[pos] += d;
            cnts[pos]++;
            if (cnts[pos] == NSMP) begin
              res_t e;
              e.idx = pos; e.data = sums[pos] / NSMP; e.done = (pos == NUM_CH - 1); e.cyc = cyc + 2;
              exp_q.push_back(e);
              sums[pos] = 0; cnts[pos] = 0;
            end
          end
        end
      end
      command_ready = !ready_hold;
      if (command_valid && command_ready) begin
        cmd_t c;
        c.ch = int'(command_channel); c.sop = command_startofpacket; c.eop = command_endofpacket;
        cmd_log.push_back(c);
        pend = 1; pend_dly = 3; pend_ch = int'(command_channel); pend_hs_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sweep_done) begin ok = 1; break; end
    end
  endtask

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); cmd_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nvec++; if (command_valid !== 1'b0) begin nmis++; $display("FAIL reset_cmd_valid: got %b expected 0", command_valid); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++; if ({result_valid, sweep_done, err_mismatch, err_timeout} !== 4'b0) begin nmis++; $display("FAIL reset_flags: got %b expected 0000", {result_valid, sweep_done, err_mismatch, err_timeout}); end
    nvec++; if ({result_index, result_data, command_channel, command_startofpacket, command_endofpacket} !== '0) begin nmis++; $display("FAIL reset_data: got idx %0d data %0d ch %0d expected 0", result_index, result_data, command_channel); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int want[NUM_CH] = '{101, 301, 801};
    clear_logs();
    seq_data = 1;
    pulse_start();
    wait_done(500, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL basic_done: sweep_done got 0 expected 1"); end
    @(negedge clk); #1;
    nvec++; if (busy !== 1'b0 || command_valid !== 1'b0) begin nmis++; $display("FAIL basic_idle: got busy %b valid %b expected 0 0", busy, command_valid); end
    nvec++; if (got_q.size() != exp_q.size()) begin nmis++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got_q[i].idx !== exp_q[i].idx || got_q[i].data !== exp_q[i].data || got_q[i].done !== exp_q[i].done || got_q[i].cyc !== exp_q[i].cyc || got_q[i].data !== want[i]) begin
        nmis++;
        $display("FAIL basic_result[%0d]: got idx %0d data %0d done %0d cyc %0d expected idx %0d data %0d done %0d cyc %0d", i, got_q[i].idx, got_q[i].data, got_q[i].done, got_q[i].cyc, exp_q[i].idx, want[i], exp_q[i].done, exp_q[i].cyc);
      end
    end
    nvec++; if (cmd_log.size() != NUM_CH * NSMP) begin nmis++; $display("FAIL basic_cmds: got %0d expected %0d", cmd_log.size(), NUM_CH * NSMP); end
    for (int i = 0; i < cmd_log.size(); i++) begin
      nvec++;
      if (cmd_log[i].sop !== (i == 0) || cmd_log[i].eop !== (i == NUM_CH * NSMP - 1) || cmd_log[i].ch !== map_ch[i / NSMP]) begin
        nmis++;
        $display("FAIL basic_cmd[%0d]: got ch %0d sop %b eop %b expected ch %0d sop %b eop %b", i, cmd_log[i].ch, cmd_log[i].sop, cmd_log[i].eop, map_ch[i / NSMP], (i == 0), (i == NUM_CH * NSMP - 1));
      end
    end
`ifdef ADC_SEQ_THRESH_EN
    nvec++; if (thresh_alarm !== 3'b100) begin nmis++; $display("FAIL thresh_alarm: got %b expected 100", thresh_alarm); end
`endif
    seq_data = 0;
  endtask

  task automatic test_ready_hold();
    bit ok, seen;
    int bad;
    clear_logs();
    ready_hold = 1;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (command_valid) seen = 1; else begin @(negedge clk); #1; end
    end
    nvec++; if (!seen) begin nmis++; $display("FAIL hold_valid: command_valid got 0 expected 1"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (command_valid !== 1'b1 || command_channel !== CH_W'(map_ch[0]) || command_startofpacket !== 1'b1) bad++;
      @(negedge clk); #1;
    end
    nvec++; if (bad != 0) begin nmis++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    nvec++; if (cmd_log.size() != 0) begin nmis++; $display("FAIL hold_accept: got %0d commands expected 0", cmd_log.size()); end
    ready_hold = 0;
    wait_done(500, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL hold_done: sweep_done got 0 expected 1"); end
    nvec++; if (cmd_log.size() != NUM_CH * NSMP) begin nmis++; $display("FAIL hold_cmds: got %0d expected %0d", cmd_log.size(), NUM_CH * NSMP); end
    nvec++; if (got_q.size() != exp_q.size()) begin nmis++; $display("FAIL hold_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got_q[i] != exp_q[i]) begin nmis++; $display("FAIL hold_result[%0d]: got idx %0d data %0d expected idx %0d data %0d", i, got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data); end
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    clear_logs();
    inj_at = -1;
    inj_arm = 1;
    pulse_start();
    wait_done(500, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL mm_done: sweep_done got 0 expected 1"); end
    nvec++; if (err_mismatch !== 1'b1 || err_timeout !== 1'b0) begin nmis++; $display("FAIL mm_flags: got mismatch %b timeout %b expected 1 0", err_mismatch, err_timeout); end
    nvec++; if (cmd_log.size() != NUM_CH * NSMP + 1) begin nmis++; $display("FAIL mm_cmds: got %0d expected %0d", cmd_log.size(), NUM_CH * NSMP + 1); end
    nvec++;
    if (inj_at < 1 || inj_at >= cmd_log.size()) begin nmis++; $display("FAIL mm_reissue: got injection point %0d expected valid", inj_at); end
    else if (cmd_log[inj_at].ch !== 3 || cmd_log[inj_at - 1].ch !== 3) begin nmis++; $display("FAIL mm_reissue: got ch %0d expected 3", cmd_log[inj_at].ch); end
    nvec++; if (got_q.size() != exp_q.size()) begin nmis++; $display("FAIL mm_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got_q[i] != exp_q[i]) begin nmis++; $display("FAIL mm_result[%0d]: got idx %0d data %0d cyc %0d expected idx %0d data %0d cyc %0d", i, got_q[i].idx, got_q[i].data, got_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].cyc); end
    end
    err_clear = 1'b1;
    @(negedge clk); #1;
    err_clear = 1'b0;
    nvec++; if (err_mismatch !== 1'b0) begin nmis++; $display("FAIL mm_clear: got %b expected 0", err_mismatch); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    sup_cyc = -1; tmo_cyc = -1;
    sup_arm = 1;
    pulse_start();
    repeat (5) @(negedge clk);
    #1;
    pulse_start();
    wait_done(600, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL tmo_done: sweep_done got 0 expected 1"); end
    nvec++; if (err_timeout !== 1'b1) begin nmis++; $display("FAIL tmo_flag: got %b expected 1", err_timeout); end
    // handshake seen one falling edge before WAIT begins; flag visible after the 20th WAIT cycle
    nvec++; if (tmo_cyc - sup_cyc != TIMEOUT_CYC + 1) begin nmis++; $display("FAIL tmo_cycle: got %0d expected %0d", tmo_cyc - sup_cyc, TIMEOUT_CYC + 1); end
    nvec++; if (cmd_log.size() != NUM_CH * NSMP + 1) begin nmis++; $display("FAIL tmo_cmds: got %0d expected %0d", cmd_log.size(), NUM_CH * NSMP + 1); end
    nvec++; if (got_q.size() != exp_q.size()) begin nmis++; $display("FAIL tmo_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got_q[i] != exp_q[i]) begin nmis++; $display("FAIL tmo_result[%0d]: got idx %0d data %0d expected idx %0d data %0d", i, got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data); end
    end
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0 || got_q.size() != NUM_CH) begin nmis++; $display("FAIL tmo_busy_start: got busy %b results %0d expected 0 %0d", busy, got_q.size(), NUM_CH); end
    err_clear = 1'b1;
    @(negedge clk); #1;
    err_clear = 1'b0;
    nvec++; if (err_timeout !== 1'b0) begin nmis++; $display("FAIL tmo_clear: got %b expected 0", err_timeout); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    continuous = 1'b1;
    pulse_start();
    wait_done(500, ok);
    nvec++; if (!ok || command_valid !== 1'b1 || busy !== 1'b1) begin nmis++; $display("FAIL b2b_restart: got done %b valid %b busy %b expected 1 1 1", ok, command_valid, busy); end
    repeat (4) @(negedge clk);
    #1;
    continuous = 1'b0;
    wait_done(500, ok);
    nvec++; if (!ok || busy !== 1'b0) begin nmis++; $display("FAIL b2b_stop: got done %b busy %b expected 1 0", ok, busy); end
    nvec++; if (got_q.size() != 2 * NUM_CH || exp_q.size() != 2 * NUM_CH) begin nmis++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), 2 * NUM_CH); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      nvec++;
      if (got_q[i] != exp_q[i]) begin nmis++; $display("FAIL b2b_result[%0d]: got idx %0d data %0d done %0d cyc %0d expected idx %0d data %0d done %0d cyc %0d", i, got_q[i].idx, got_q[i].data, got_q[i].done, got_q[i].cyc, exp_q[i].idx, exp_q[i].data, exp_q[i].done, exp_q[i].cyc); end
    end
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0 || command_valid !== 1'b0 || got_q.size() != 2 * NUM_CH) begin nmis++; $display("FAIL b2b_idle: got busy %b valid %b results %0d expected 0 0 %0d", busy, command_valid, got_q.size(), 2 * NUM_CH); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (command_valid && command_ready) seen = 1; else begin @(negedge clk); #1; end
    end
    nvec++; if (!seen) begin nmis++; $display("FAIL rstmid_handshake: got none expected one"); end
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    nvec++; if ({command_valid, busy, result_valid, sweep_done, err_mismatch, err_timeout} !== 6'b0) begin nmis++; $display("FAIL rstmid_outputs: got %b expected 000000", {command_valid, busy, result_valid, sweep_done, err_mismatch, err_timeout}); end
    nvec++; if ({result_index, result_data, command_channel} !== '0) begin nmis++; $display("FAIL rstmid_data: got idx %0d data %0d ch %0d expected 0", result_index, result_data, command_channel); end
    pend = 0;
    for (int i = 0; i < NUM_CH; i++) begin sums[i] = 0; cnts[i] = 0; end
    got_q.delete(); exp_q.delete();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    nvec++; if (got_q.size() != 0 || busy !== 1'b0) begin nmis++; $display("FAIL rstmid_quiet: got results %0d busy %b expected 0 0", got_q.size(), busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; err_clear = 1'b0;
`ifdef ADC_SEQ_THRESH_EN
    thresh_hi = DATA_W'(500);
`endif
    test_reset();
    test_basic();
    test_ready_hold();
    test_mismatch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
